dac_tx: RTL and testbench
=========================

# dac_tx

Serial transmitter for the 12-bit DAC output stage (DAC121S101-type on the DA2 module). It is the playback-side counterpart of the ADC capture path. It accepts a 12-bit sample with a single-cycle start handshake and builds a 16-bit frame. The frame is shifted MSB-first on `sdata` using an internally generated `sclk` and an active-low `sync` frame strobe. The block sits between the equalizer output register and the DAC header pins, and runs entirely in the 100 MHz system clock domain.

## Interface
- `CLK_DIV`, default 4: `sclk` half-period in `clk` cycles, so `sclk` = `clk`/(2·`CLK_DIV`). Legal range is ≥ 2; the default gives 12.5 MHz.
- `PD_MODE`, default 2'b00: DAC power-down control bits placed in frame bits [13:12].
- `clk`, input, 1: 100 MHz system clock. All logic uses its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `tx_start`, input, 1: request a frame. Sampled only in IDLE.
- `din`, input, 12: sample to send. Latched on the cycle `tx_start` is accepted.
- `busy`, output, 1: high from the cycle after acceptance until the block returns to IDLE.
- `tx_done_tick`, output, 1: one-`clk` pulse when the last bit period ends.
- `sclk`, output, 1: serial clock to the DAC. Idles high.
- `sync`, output, 1: active-low frame strobe to the DAC.
- `sdata`, output, 1: serial data to the DAC. Sampled by the DAC on `sclk` falling edges.

## Operation
- Frame layout (16 bits, MSB first): [15:14] = 2'b00, [13:12] = `PD_MODE`, [11:0] = `din`.
- FSM states: IDLE, SHIFT, QUIET.
- IDLE
  - Outputs: `sync` = 1, `sclk` = 1, `sdata` = 0, `busy` = 0.
  - When `tx_start` = 1, latch the frame into a 16-bit shift register, clear the bit and divider counters, and go to SHIFT.
- SHIFT
  - Outputs: `sync` = 0, `busy` = 1. `sdata` is the shift register MSB.
  - Each bit period is 2·`CLK_DIV` cycles: first `CLK_DIV` cycles `sclk` = 1, next `CLK_DIV` cycles `sclk` = 0.
  - At each period boundary the register shifts left and `sclk` rises together with the new `sdata`.
  - After 16 periods go to QUIET.
- QUIET
  - Outputs: `sync` = 1, `sclk` = 1, `sdata` = 0, `busy` = 1.
  - `tx_done_tick` = 1 on the first QUIET cycle only.
  - Lasts `CLK_DIV` cycles to meet the minimum `sync`-high time, then returns to IDLE.
- Boundary behaviour:
  - `tx_start` in SHIFT or QUIET is ignored and not queued; `din` is don't-care outside acceptance.
  - If `tx_start` is held high continuously, a new frame is accepted on the first IDLE cycle.
  - Reset asserted mid-frame forces IDLE outputs asynchronously. No `tx_done_tick` is produced, and the partial frame is discarded.
  - Counter widths are sized from `CLK_DIV` (clog2). The bit counter is 4 bits and stops the frame at terminal count 15; it never wraps into a 17th bit.
- All outputs are driven directly from flops (glitch-free `sclk`, `sync`, `sdata`).

## Timing
- Reset values: `sync` = 1, `sclk` = 1, `sdata` = 0, `busy` = 0, `tx_done_tick` = 0, state = IDLE.
- Let cycle 0 be the edge that accepts `tx_start`.
- From cycle 1:
  - `sync` falls, `busy` rises, and `sdata` = frame[15].
  - `sclk` is high for cycles 1..`CLK_DIV` and low for cycles `CLK_DIV`+1..2·`CLK_DIV`.
- Bit k (0 = MSB) is driven during cycles 1+2k·`CLK_DIV` .. (2k+2)·`CLK_DIV`. Its `sclk` falling edge is at cycle 1+(2k+1)·`CLK_DIV`.
- Data setup and hold around each falling edge are both `CLK_DIV` `clk` cycles.
- `sync` rises and `tx_done_tick` pulses at cycle 1+32·`CLK_DIV`.
- `busy` falls at cycle 1+33·`CLK_DIV`, which is also the earliest cycle a new start can be accepted.
- With `CLK_DIV` = 4: 16 falling edges, done at cycle 129, frame-to-frame period of 133 cycles.

## Test plan
- Reset: hold `rst` = 0 for 5 cycles, release -> `sync` = 1, `sclk` = 1, `sdata` = 0, `busy` = 0, `tx_done_tick` = 0, with no toggling for 50 cycles.
- Single frame, defaults, `din` = 12'hA5C -> exactly 16 `sclk` falls while `sync` = 0. Bits captured on the falls are 0000_1010_0101_1100; `tx_done_tick` is high only at cycle 129; `busy` is low at cycle 133.
- `tx_start` held high with `din` = 12'h001 then 12'hFFE -> two frames. The gap between the first `sync` rise and the second `sync` fall is `CLK_DIV` + 1 = 5 cycles; the captured frames are 16'h0001 and 16'h0FFE.
- `tx_start` pulsed at cycles 20 and 100 of a frame with `din` = 12'h777 -> ignored. The frame carries the originally latched data, and only one `tx_done_tick` occurs.
- Reset asserted at cycle 60 of a frame -> IDLE outputs within the same cycle, with no `tx_done_tick`. The next start produces a complete, correct frame.
- `CLK_DIV` = 2, `PD_MODE` = 2'b11, `din` = 12'hFFF -> frame 16'h3FFF, `sclk` period of 4 cycles, `tx_done_tick` at cycle 65.

Source files
------------

// File: rtl/dac_tx.sv
// Serial transmitter for a DAC121S101-class DAC: 16-bit frames shifted MSB first
// on sdata with a divided-down sclk and an active-low sync strobe.
module dac_tx #(
   parameter int unsigned CLK_DIV = 4,
   parameter logic [1:0]  PD_MODE = 2'b00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_start,
   input  logic [11:0] din,
   output logic        busy,
   output logic        tx_done_tick,
   output logic        sclk,
   output logic        sync,
   output logic        sdata
);

   localparam int unsigned     DivW       = $clog2(2 * CLK_DIV);
   localparam logic [DivW-1:0] PeriodLast = DivW'(2 * CLK_DIV - 1);
   localparam logic [DivW-1:0] HalfCnt    = DivW'(CLK_DIV);
   localparam logic [DivW-1:0] QuietLast  = DivW'(CLK_DIV - 1);

   typedef enum logic [1:0] {StIdle, StShift, StQuiet} state_e;

   state_e            state_q, state_d;
   logic [DivW-1:0]   div_q, div_d;
   logic [3:0]        bit_q, bit_d;
   logic [15:0]       shreg_q, shreg_d;
   logic              sclk_q, sclk_d;
   logic              sync_q, sync_d;
   logic              sdata_q, sdata_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Output flops are loaded with the values for the next cycle, so every pin
   // comes straight from a register.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      sclk_d  = 1'b1;
      sync_d  = 1'b1;
      sdata_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (tx_start) begin
               state_d = StShift;
               div_d   = '0;
               bit_d   = '0;
               shreg_d = {2'b00, PD_MODE, din};
               sync_d  = 1'b0;
               busy_d  = 1'b1;
               sdata_d = shreg_d[15];
            end
         end
         StShift: begin
            busy_d = 1'b1;
            sync_d = 1'b0;
            if (div_q == PeriodLast) begin
               div_d = '0;
               // Terminal count on the 16th bit: never wraps into a 17th
               if (bit_q == 4'd15) begin
                  state_d = StQuiet;
                  sync_d  = 1'b1;
                  done_d  = 1'b1;
               end else begin
                  bit_d   = bit_q + 4'd1;
                  shreg_d = {shreg_q[14:0], 1'b0};
               end
            end else begin
               div_d = div_q + 1'b1;
            end
            if (state_d == StShift) begin
               sclk_d  = (div_d < HalfCnt);
               sdata_d = shreg_d[15];
            end
         end
         StQuiet: begin
            busy_d = 1'b1;
            if (div_q == QuietLast) begin
               state_d = StIdle;
               busy_d  = 1'b0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         div_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         sclk_q  <= 1'b1;
         sync_q  <= 1'b1;
         sdata_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         sclk_q  <= sclk_d;
         sync_q  <= sync_d;
         sdata_q <= sdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign sclk         = sclk_q;
   assign sync         = sync_q;
   assign sdata        = sdata_q;
   assign busy         = busy_q;
   assign tx_done_tick = done_q;

endmodule

// File: tb/tb_dac_tx.sv
// Bench for dac_tx: random and directed frames on a default instance and a
// CLK_DIV=2 / PD_MODE=3 instance, decoded from the serial pins.
module tb_dac_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_start;
   logic [11:0] din;
   logic        busy1, done1, sclk1, sync1, sdata1;
   logic        busy2, done2, sclk2, sync2, sdata2;
   logic        sel;
   logic        o_busy, o_done, o_sclk, o_sync, o_sdata;

   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   dac_tx dut1 (
      .clk          (clk),
      .rst          (rst),
      .tx_start     (tx_start),
      .din          (din),
      .busy         (busy1),
      .tx_done_tick (done1),
      .sclk         (sclk1),
      .sync         (sync1),
      .sdata        (sdata1)
   );

   dac_tx #(
      .CLK_DIV (2),
      .PD_MODE (2'b11)
   ) dut2 (
      .clk          (clk),
      .rst          (rst),
      .tx_start     (tx_start),
      .din          (din),
      .busy         (busy2),
      .tx_done_tick (done2),
      .sclk         (sclk2),
      .sync         (sync2),
      .sdata        (sdata2)
   );

   always_comb begin
      o_busy  = sel ? busy2  : busy1;
      o_done  = sel ? done2  : done1;
      o_sclk  = sel ? sclk2  : sclk1;
      o_sync  = sel ? sync2  : sync1;
      o_sdata = sel ? sdata2 : sdata1;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait for the selected DUT to be idle, then request a frame on the next edge.
   task automatic start_frame(input logic [11:0] d);
      bit ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (!o_busy) begin
            ok = 1'b1;
            break;
         end
      end
      check("idle_before_start", int'(ok), 1);
      din      = d;
      tx_start = 1'b1;
   endtask

   // Observe one frame from cycle 1 (first negedge after the accepting edge).
   task automatic watch_frame(input int cdiv, input bit hold, input logic [11:0] next_din,
                              input int ga, input int gb,
                              output logic [15:0] bits, output int nfalls,
                              output int f1, output int f2, output int done_cyc,
                              output int ndone, output int rise_cyc, output int fall_cyc,
                              output logic first_sync);
      logic prev_sclk = 1'b1;
      bits = '0; nfalls = 0; f1 = -1; f2 = -1; done_cyc = -1; ndone = 0;
      rise_cyc = -1; fall_cyc = -1; first_sync = 1'b1;
      for (int c = 1; c <= 40 * cdiv + 20; c++) begin
         @(negedge clk);
         if (c == 1) first_sync = o_sync;
         if (prev_sclk && !o_sclk && !o_sync) begin
            bits = {bits[14:0], o_sdata};
            nfalls++;
            if (nfalls == 1) f1 = c;
            if (nfalls == 2) f2 = c;
         end
         prev_sclk = o_sclk;
         if (o_done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (rise_cyc < 0 && c > 1 && o_sync) rise_cyc = c;
         if (!o_busy) begin
            fall_cyc = c;
            if (hold) din = next_din;
            break;
         end
         tx_start = hold || c == ga || c == gb;
         if (c == ga || c == gb) din = 12'h777;
      end
   endtask

   logic [15:0] bits;
   int          nfalls, f1, f2, done_cyc, ndone, rise_cyc, fall_cyc;
   logic        first_sync;

   // Compare one observed frame against the frame-level timing rules.
   task automatic check_frame(input string tag, input int cdiv, input logic [15:0] exp_bits);
      check({tag, "_first_sync"}, int'(first_sync), 0);
      check({tag, "_bits"}, int'(bits), int'(exp_bits));
      check({tag, "_nfalls"}, nfalls, 16);
      check({tag, "_fall0"}, f1, 1 + cdiv);
      check({tag, "_sclk_period"}, f2 - f1, 2 * cdiv);
      check({tag, "_done_cyc"}, done_cyc, 1 + 32 * cdiv);
      check({tag, "_ndone"}, ndone, 1);
      check({tag, "_sync_rise"}, rise_cyc, 1 + 32 * cdiv);
      check({tag, "_busy_fall"}, fall_cyc, 1 + 33 * cdiv);
   endtask

   initial begin
      logic [11:0] d;
      int          bad;
      rst = 1'b0; tx_start = 1'b0; din = '0; sel = 1'b0;

      // Reset behaviour
      repeat (5) @(negedge clk);
      check("rst_sync", int'(o_sync), 1);
      check("rst_sclk", int'(o_sclk), 1);
      check("rst_busy", int'(o_busy), 0);
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!o_sync || !o_sclk || o_sdata || o_busy || o_done) bad++;
      end
      check("rst_quiet_50", bad, 0);

      // Directed single frame
      start_frame(12'hA5C);
      watch_frame(4, 1'b0, 12'h000, -1, -1, bits, nfalls, f1, f2, done_cyc, ndone,
                  rise_cyc, fall_cyc, first_sync);
      check_frame("a5c", 4, 16'h0A5C);

      // Randomized frames on the default instance
      for (int n = 0; n < 6; n++) begin
         d = 12'($urandom_range(0, 4095));
         start_frame(d);
         watch_frame(4, 1'b0, 12'h000, -1, -1, bits, nfalls, f1, f2, done_cyc, ndone,
                     rise_cyc, fall_cyc, first_sync);
         check_frame("rand", 4, {2'b00, 2'b00, d});
      end

      // tx_start held high: back-to-back frames
      start_frame(12'h001);
      watch_frame(4, 1'b1, 12'hFFE, -1, -1, bits, nfalls, f1, f2, done_cyc, ndone,
                  rise_cyc, fall_cyc, first_sync);
      check_frame("hold1", 4, 16'h0001);
      d = 12'(rise_cyc);
      watch_frame(4, 1'b0, 12'h000, -1, -1, bits, nfalls, f1, f2, done_cyc, ndone,
                  rise_cyc, fall_cyc, first_sync);
      check("hold_gap", (1 + 33 * 4 + 1) - int'(d), 5);
      check_frame("hold2", 4, 16'h0FFE);

      // tx_start pulses mid-frame are ignored
      start_frame(12'h35A);
      watch_frame(4, 1'b0, 12'h000, 20, 100, bits, nfalls, f1, f2, done_cyc, ndone,
                  rise_cyc, fall_cyc, first_sync);
      check_frame("ignore", 4, 16'h035A);
      repeat (10) @(negedge clk);
      check("ignore_no_restart", int'(o_busy), 0);

      // Reset in the middle of a frame
      start_frame(12'h9C3);
      @(negedge clk);
      tx_start = 1'b0;
      repeat (58) @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_sync", int'(o_sync), 1);
      check("midrst_sclk", int'(o_sclk), 1);
      check("midrst_sdata", int'(o_sdata), 0);
      check("midrst_busy", int'(o_busy), 0);
      bad = 0;
      for (int i = 0; i < 140; i++) begin
         @(negedge clk);
         if (i == 3) rst = 1'b1;
         if (o_done || o_busy) bad++;
      end
      check("midrst_no_done", bad, 0);
      d = 12'($urandom_range(0, 4095));
      start_frame(d);
      watch_frame(4, 1'b0, 12'h000, -1, -1, bits, nfalls, f1, f2, done_cyc, ndone,
                  rise_cyc, fall_cyc, first_sync);
      check_frame("after_rst", 4, {4'b0000, d});

      // CLK_DIV=2, PD_MODE=3 instance
      sel = 1'b1;
      start_frame(12'hFFF);
      watch_frame(2, 1'b0, 12'h000, -1, -1, bits, nfalls, f1, f2, done_cyc, ndone,
                  rise_cyc, fall_cyc, first_sync);
      check_frame("div2_fff", 2, 16'h3FFF);
      for (int n = 0; n < 4; n++) begin
         d = 12'($urandom_range(0, 4095));
         start_frame(d);
         watch_frame(2, 1'b0, 12'h000, -1, -1, bits, nfalls, f1, f2, done_cyc, ndone,
                     rise_cyc, fall_cyc, first_sync);
         check_frame("div2_rand", 2, {2'b00, 2'b11, d});
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
